ifid_skid_reg: RTL and testbench
================================

Name: ifid_skid_reg

Overview:
- Parametrised IF/ID pipeline stage register, successor to the fixed 32-bit IF/ID latch.
- Sits between the fetch stage and decode.
- Adds a valid/ready handshake toward fetch, a one-entry skid buffer so a fetched beat is never lost under decode stall, and flush with a configurable NOP bubble.
- Adds stage-status and stall-length observability for the hazard unit and debug.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, width of PC+4 field.
- NOP_INSTR, 32'h0000_0000, value driven on OUT_INSTRUCTION when stage is empty or flushed (width INSTR_W).
- CNT_W, 8, width of consecutive-stall counter.

Ports:
- CLK  in  1  stage clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset (asserted when 0).
- IN_VALID  in  1  fetch presents a beat.
- IN_READY  out  1  stage can accept a beat; equals !skid_valid; registered state only, no combinational path from IN_VALID.
- IN_INSTR  in  INSTR_W  fetched instruction.
- IN_PC_4  in  PC_W  fetched PC+4.
- STALL  in  1  decode hold (inverse of IFIDWrite); output register holds.
- FLUSH_REQ  in  1  synchronous flush from branch/jump resolution.
- OUT_VALID  out  1  OUT_* carries a real instruction.
- OUT_INSTRUCTION  out  INSTR_W  instruction to decode.
- OUT_PC_4  out  PC_W  PC+4 to decode.
- OUT_FLUSH  out  1  one-cycle pulse: stage was flushed on the last edge.
- TYPE  out  3  last-edge action code: 1=reset, 2=flush, 3=load, 4=hold, 5=bubble.
- STALL_CNT  out  CNT_W  consecutive stall cycles, saturating.

Behaviour:
- Accept condition: acc = IN_VALID & IN_READY, sampled at the clock edge.
- Reset (RESET=0, asynchronous, any cycle including mid-stall or mid-skid):
  - OUT_VALID=0, OUT_INSTRUCTION=NOP_INSTR, OUT_PC_4=0, OUT_FLUSH=0.
  - Skid emptied, so IN_READY=1.
  - TYPE=1, STALL_CNT=0.
  - First edge after deassertion follows the normal priority rules below.
- Per-edge priority: FLUSH_REQ > STALL > advance.
- FLUSH_REQ=1 (regardless of STALL):
  - OUT_VALID=0, OUT_INSTRUCTION=NOP_INSTR, OUT_PC_4=0, OUT_FLUSH=1, TYPE=2.
  - Skid cleared; a beat accepted on this edge is discarded.
  - STALL_CNT=0.
- STALL=1, no flush:
  - OUT_* hold; OUT_FLUSH=0; TYPE=4.
  - If acc: beat written to skid; IN_READY drops to 0 next cycle.
  - STALL_CNT increments, saturating at 2^CNT_W-1 with no wrap.
- STALL=0, no flush (advance):
  - If skid valid: OUT_* <= skid, OUT_VALID=1, skid emptied, TYPE=3. No acc is possible because IN_READY=0.
  - Else if acc: OUT_* <= IN_*, OUT_VALID=1, TYPE=3.
  - Else: OUT_VALID=0, OUT_INSTRUCTION=NOP_INSTR, OUT_PC_4=0, TYPE=5 (bubble).
  - OUT_FLUSH=0, STALL_CNT=0.
- Latency: one edge from accept to OUT when skid is empty; skid adds one edge.
- Ordering: beats leave strictly in accept order; no duplication or loss except on flush.
- Simultaneous events:
  - Flush with a full skid: both the skid beat and the output beat are dropped.
  - Stall release in the same cycle fetch is blocked: the skid drains first, and IN_READY rises one cycle later.

Test Plan:
- Reset: hold RESET=0 with IN_VALID=1 -> OUT_VALID=0, OUT_INSTRUCTION=NOP_INSTR, TYPE=1, IN_READY=1. Release, present 0x2002_0005/PC4 0x4 -> next edge OUT=0x2002_0005/0x4, TYPE=3.
- Stall with skid: load A=0x1111_1111, then STALL=1 and present B=0x2222_2222 -> OUT holds A, TYPE=4, IN_READY=0 next cycle. Release STALL -> OUT=B, IN_READY=1; no beat lost.
- Flush during full skid: A in OUT, B in skid, FLUSH_REQ=1 with STALL=1 -> OUT_VALID=0, OUT_INSTRUCTION=NOP_INSTR, OUT_FLUSH=1 for exactly one cycle, TYPE=2, IN_READY=1. B never appears.
- Bubble: IN_VALID=0 with STALL=0 -> OUT_VALID=0, TYPE=5. With NOP_INSTR=0x0000_0020 the bubble instruction reads 0x0000_0020.
- Stall counter, CNT_W=3: STALL=1 for 10 cycles -> STALL_CNT reads 1..7 then holds 7. STALL=0 -> 0.
- Async reset mid-stall: A in OUT, B in skid, RESET=0 between edges -> outputs clear immediately, without waiting for CLK.

Source files
------------

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline stage register with a valid/ready handshake toward fetch, a one-entry
// skid buffer that absorbs a beat arriving during a decode stall, and flush-to-NOP.
module ifid_skid_reg #(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
   parameter int                 CNT_W     = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [INSTR_W-1:0] IN_INSTR,
   input  logic [PC_W-1:0]    IN_PC_4,
   input  logic               STALL,
   input  logic               FLUSH_REQ,
   output logic               OUT_VALID,
   output logic [INSTR_W-1:0] OUT_INSTRUCTION,
   output logic [PC_W-1:0]    OUT_PC_4,
   output logic               OUT_FLUSH,
   output logic [2:0]         TYPE,
   output logic [CNT_W-1:0]   STALL_CNT
);

   // Action taken on the most recent edge; doubles as the stage's observable status.
   typedef enum logic [2:0] {
      ACT_RESET  = 3'd1,
      ACT_FLUSH  = 3'd2,
      ACT_LOAD   = 3'd3,
      ACT_HOLD   = 3'd4,
      ACT_BUBBLE = 3'd5
   } action_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   action_t            action;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               out_flush;
   logic [CNT_W-1:0]   stall_cnt;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;
   logic               acc;

   // Handshake: a beat transfers on a clock edge where IN_VALID and IN_READY are both 1.
   // IN_READY depends only on registered state, so fetch never sees a combinational loop.
   assign IN_READY = ~skid_valid;
   assign acc      = IN_VALID & ~skid_valid;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         out_valid  <= 1'b0;
         out_instr  <= NOP_INSTR;
         out_pc     <= '0;
         out_flush  <= 1'b0;
         action     <= ACT_RESET;
         stall_cnt  <= '0;
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (FLUSH_REQ) begin
         // Flush wins over stall and drops both the output beat and any skid beat.
         out_valid  <= 1'b0;
         out_instr  <= NOP_INSTR;
         out_pc     <= '0;
         out_flush  <= 1'b1;
         action     <= ACT_FLUSH;
         stall_cnt  <= '0;
         skid_valid <= 1'b0;
      end else if (STALL) begin
         out_flush <= 1'b0;
         action    <= ACT_HOLD;
         if (stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (acc) begin
            skid_valid <= 1'b1;
            skid_instr <= IN_INSTR;
            skid_pc    <= IN_PC_4;
         end
      end else begin
         out_flush <= 1'b0;
         stall_cnt <= '0;
         if (skid_valid) begin
            // Older skid beat drains first; fetch is blocked this cycle by IN_READY=0.
            out_valid  <= 1'b1;
            out_instr  <= skid_instr;
            out_pc     <= skid_pc;
            skid_valid <= 1'b0;
            action     <= ACT_LOAD;
         end else if (acc) begin
            out_valid <= 1'b1;
            out_instr <= IN_INSTR;
            out_pc    <= IN_PC_4;
            action    <= ACT_LOAD;
         end else begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= '0;
            action    <= ACT_BUBBLE;
         end
      end
   end

   assign OUT_VALID       = out_valid;
   assign OUT_INSTRUCTION = out_instr;
   assign OUT_PC_4        = out_pc;
   assign OUT_FLUSH       = out_flush;
   assign TYPE            = action;
   assign STALL_CNT       = stall_cnt;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed bench for ifid_skid_reg: a beat-level model checked every cycle plus literal pins.
module tb_ifid_skid_reg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam int CNT_W   = 3;
   localparam logic [31:0] NOP = 32'h0000_0020;
   localparam logic [2:0] T_RESET = 3'd1, T_FLUSH = 3'd2, T_LOAD = 3'd3, T_HOLD = 3'd4, T_BUBBLE = 3'd5;

   logic               CLK = 1'b0;
   logic               RESET = 1'b1;
   logic               IN_VALID = 1'b0;
   logic               IN_READY;
   logic [INSTR_W-1:0] IN_INSTR = '0;
   logic [PC_W-1:0]    IN_PC_4 = '0;
   logic               STALL = 1'b0;
   logic               FLUSH_REQ = 1'b0;
   logic               OUT_VALID;
   logic [INSTR_W-1:0] OUT_INSTRUCTION;
   logic [PC_W-1:0]    OUT_PC_4;
   logic               OUT_FLUSH;
   logic [2:0]         TYPE;
   logic [CNT_W-1:0]   STALL_CNT;

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   ifid_skid_reg #(
      .INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_INSTR(IN_INSTR), .IN_PC_4(IN_PC_4), .STALL(STALL), .FLUSH_REQ(FLUSH_REQ),
      .OUT_VALID(OUT_VALID), .OUT_INSTRUCTION(OUT_INSTRUCTION), .OUT_PC_4(OUT_PC_4),
      .OUT_FLUSH(OUT_FLUSH), .TYPE(TYPE), .STALL_CNT(STALL_CNT)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // Beat-level model: "pending" is a beat fetch handed over that decode has not yet seen.
   logic        m_valid = 1'b0, m_flush = 1'b0, m_pend = 1'b0;
   logic [31:0] m_instr = NOP, m_pc = '0, m_pend_i = '0, m_pend_p = '0;
   logic [2:0]  m_type = T_RESET;
   int          m_cnt = 0;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_valid <= 1'b0; m_instr <= NOP; m_pc <= '0; m_flush <= 1'b0;
         m_type <= T_RESET; m_cnt <= 0; m_pend <= 1'b0;
      end else if (FLUSH_REQ) begin
         m_valid <= 1'b0; m_instr <= NOP; m_pc <= '0; m_flush <= 1'b1;
         m_type <= T_FLUSH; m_cnt <= 0; m_pend <= 1'b0;
      end else if (STALL) begin
         m_flush <= 1'b0; m_type <= T_HOLD;
         m_cnt <= (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
         if (IN_VALID && !m_pend) begin
            m_pend <= 1'b1; m_pend_i <= IN_INSTR; m_pend_p <= IN_PC_4;
         end
      end else begin
         m_flush <= 1'b0; m_cnt <= 0;
         if (m_pend) begin
            m_valid <= 1'b1; m_instr <= m_pend_i; m_pc <= m_pend_p; m_pend <= 1'b0; m_type <= T_LOAD;
         end else if (IN_VALID) begin
            m_valid <= 1'b1; m_instr <= IN_INSTR; m_pc <= IN_PC_4; m_type <= T_LOAD;
         end else begin
            m_valid <= 1'b0; m_instr <= NOP; m_pc <= '0; m_type <= T_BUBBLE;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge CLK) begin
      if (run) begin
         check("m_ready", {63'd0, IN_READY}, {63'd0, !m_pend});
         check("m_valid", {63'd0, OUT_VALID}, {63'd0, m_valid});
         check("m_instr", {32'd0, OUT_INSTRUCTION}, {32'd0, m_instr});
         check("m_pc", {32'd0, OUT_PC_4}, {32'd0, m_pc});
         check("m_flush", {63'd0, OUT_FLUSH}, {63'd0, m_flush});
         check("m_type", {61'd0, TYPE}, {61'd0, m_type});
         check("m_cnt", {61'd0, STALL_CNT}, 64'(m_cnt));
      end
   end

   // driver: present inputs, let one edge pass, land 1 time unit after it
   task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
      IN_VALID = iv; IN_INSTR = ins; IN_PC_4 = pc; STALL = st; FLUSH_REQ = fl;
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_out(input string name, input logic v, input logic [31:0] ins,
                             input logic [31:0] pc, input logic [2:0] t, input logic rdy);
      check({name, ".valid"}, {63'd0, OUT_VALID}, {63'd0, v});
      check({name, ".instr"}, {32'd0, OUT_INSTRUCTION}, {32'd0, ins});
      check({name, ".pc"}, {32'd0, OUT_PC_4}, {32'd0, pc});
      check({name, ".type"}, {61'd0, TYPE}, {61'd0, t});
      check({name, ".ready"}, {63'd0, IN_READY}, {63'd0, rdy});
   endtask

   initial begin
      #2 RESET = 1'b0;
      run = 1'b1;
      IN_VALID = 1'b1; IN_INSTR = 32'hDEAD_BEEF; IN_PC_4 = 32'h40;
      repeat (2) @(posedge CLK);
      #1;
      expect_out("reset", 1'b0, NOP, 32'h0, T_RESET, 1'b1);
      check("reset.flush", {63'd0, OUT_FLUSH}, 64'd0);
      check("reset.cnt", {61'd0, STALL_CNT}, 64'd0);
      RESET = 1'b1;

      step(1'b1, 32'h2002_0005, 32'h4, 1'b0, 1'b0);
      expect_out("first_load", 1'b1, 32'h2002_0005, 32'h4, T_LOAD, 1'b1);

      // stall with a beat landing in the skid
      step(1'b1, 32'h1111_1111, 32'h8, 1'b0, 1'b0);
      expect_out("load_a", 1'b1, 32'h1111_1111, 32'h8, T_LOAD, 1'b1);
      step(1'b1, 32'h2222_2222, 32'hC, 1'b1, 1'b0);
      expect_out("stall_skid", 1'b1, 32'h1111_1111, 32'h8, T_HOLD, 1'b0);
      check("stall_skid.cnt", {61'd0, STALL_CNT}, 64'd1);
      // release while fetch already offers C: skid drains first, C waits
      step(1'b1, 32'h3333_3333, 32'h10, 1'b0, 1'b0);
      expect_out("drain_b", 1'b1, 32'h2222_2222, 32'hC, T_LOAD, 1'b1);
      check("drain_b.cnt", {61'd0, STALL_CNT}, 64'd0);
      step(1'b1, 32'h3333_3333, 32'h10, 1'b0, 1'b0);
      expect_out("load_c", 1'b1, 32'h3333_3333, 32'h10, T_LOAD, 1'b1);

      // flush while stalled with a full skid
      step(1'b1, 32'h4444_4444, 32'h14, 1'b1, 1'b0);
      expect_out("skid_d", 1'b1, 32'h3333_3333, 32'h10, T_HOLD, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      expect_out("flush", 1'b0, NOP, 32'h0, T_FLUSH, 1'b1);
      check("flush.pulse", {63'd0, OUT_FLUSH}, 64'd1);
      check("flush.cnt", {61'd0, STALL_CNT}, 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      expect_out("bubble", 1'b0, NOP, 32'h0, T_BUBBLE, 1'b1);
      check("flush.one_cycle", {63'd0, OUT_FLUSH}, 64'd0);

      // a beat accepted on a flush edge is discarded
      step(1'b1, 32'h5555_5555, 32'h18, 1'b0, 1'b1);
      expect_out("flush_acc", 1'b0, NOP, 32'h0, T_FLUSH, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      expect_out("flush_acc_gone", 1'b0, NOP, 32'h0, T_BUBBLE, 1'b1);

      // saturating stall counter (CNT_W=3)
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         check("stall_cnt", {61'd0, STALL_CNT}, 64'((i > 7) ? 7 : i));
      end
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("stall_cnt_clear", {61'd0, STALL_CNT}, 64'd0);

      // asynchronous reset mid-stall with a full skid
      step(1'b1, 32'h1111_1111, 32'h8, 1'b0, 1'b0);
      step(1'b1, 32'h2222_2222, 32'hC, 1'b1, 1'b0);
      expect_out("pre_areset", 1'b1, 32'h1111_1111, 32'h8, T_HOLD, 1'b0);
      #1 RESET = 1'b0;
      #1;
      expect_out("areset", 1'b0, NOP, 32'h0, T_RESET, 1'b1);
      check("areset.cnt", {61'd0, STALL_CNT}, 64'd0);
      IN_VALID = 1'b0; STALL = 1'b0;
      @(posedge CLK);
      #1 RESET = 1'b1;
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      expect_out("post_areset", 1'b0, NOP, 32'h0, T_BUBBLE, 1'b1);

      // back-to-back streaming with no stall
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
         expect_out("stream", 1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), T_LOAD, 1'b1);
      end

      @(negedge CLK);
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
